// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and FSM encoding for the 8-slot TDM frame receiver
package tdm_pkg;
    localparam int WIDTH = 16;
    localparam int SLOTS = 8;
    localparam int IDX_W = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/tdm_frame_rx_if.sv
// tdm_frame_rx_if: word-in / frame-out handshake bundle of the TDM frame receiver
interface tdm_frame_rx_if #(parameter int WIDTH = tdm_pkg::WIDTH);
    logic in_valid, in_sof, in_ready, frame_valid, frame_ready, sync_err;
    logic [0:WIDTH-1] in_data, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
    logic [0:7] frame_cnt;
    modport master(output in_valid, in_sof, in_data, frame_ready,
                   input in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
                   frame_valid, sync_err, frame_cnt);
    modport slave(input in_valid, in_sof, in_data, frame_ready,
                  output in_ready, out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h,
                  frame_valid, sync_err, frame_cnt);
endinterface

// File: rtl/tdm_frame_rx_slot_load_decoder.sv
// slot_load_decoder: steers a write strobe to one of eight one-hot slot load enables
module slot_load_decoder
    import tdm_pkg::*;
(
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    output logic [SLOTS-1:0] ld
);
    always_comb ld = we ? SLOTS'(1) << idx : '0;
endmodule

// File: rtl/tdm_frame_rx.sv
// tdm_frame_rx: reassembles eight slot words into a parallel frame with valid/ready output
module tdm_frame_rx
    import tdm_pkg::*;
(
    input logic           clock,
    input logic           reset,
    tdm_frame_rx_if.slave bus
);
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [0:WIDTH-1] slot [SLOTS];
    logic             frame_valid, sync_err;
    logic [0:7]       frame_cnt;
    logic             acc, sof_acc, we;
    logic [SLOTS-1:0] ld;

    assign bus.in_ready = !frame_valid || bus.frame_ready;
    assign acc = bus.in_valid && bus.in_ready;
    assign sof_acc = acc && bus.in_sof;
    // a sof word always lands in slot 0, whatever state it arrives in
    assign we = sof_acc || (acc && state == COLLECT);

    slot_load_decoder u_dec (.we(we), .idx(bus.in_sof ? IDX_W'(0) : idx), .ld(ld));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            frame_valid <= 1'b0;
            sync_err <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
        end else begin
            // sof is only legal outside COLLECT, continuation words only inside it
            sync_err <= acc && (bus.in_sof == (state == COLLECT));
            for (int i = 0; i < SLOTS; i++) if (ld[i]) slot[i] <= bus.in_data;
            case (state)
                IDLE: if (sof_acc) begin
                    idx <= IDX_W'(1);
                    state <= COLLECT;
                end
                COLLECT: if (sof_acc) idx <= IDX_W'(1);
                else if (acc) begin
                    if (idx == IDX_W'(SLOTS - 1)) begin
                        frame_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                        idx <= '0;
                        state <= HOLD;
                    end else idx <= idx + IDX_W'(1);
                end
                HOLD: if (bus.frame_ready) begin
                    frame_valid <= 1'b0;
                    idx <= sof_acc ? IDX_W'(1) : IDX_W'(0);
                    state <= sof_acc ? COLLECT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_a = slot[0];
    assign bus.out_b = slot[1];
    assign bus.out_c = slot[2];
    assign bus.out_d = slot[3];
    assign bus.out_e = slot[4];
    assign bus.out_f = slot[5];
    assign bus.out_g = slot[6];
    assign bus.out_h = slot[7];
    assign bus.frame_valid = frame_valid;
    assign bus.sync_err = sync_err;
    assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_tdm_frame_rx.sv
// tb_tdm_frame_rx: directed table plus hand sequences for the TDM frame receiver
module tb_tdm_frame_rx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rdy_pre;
    int total = 0;
    int passed = 0;

    always #5 clock = ~clock;

    tdm_frame_rx_if bus();
    tdm_frame_rx dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic v, s;
        logic [15:0] d;
        logic fr, rdy, fv, se;
        logic [7:0] cnt;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] outs(input int i);
        case (i)
            0: return bus.out_a;
            1: return bus.out_b;
            2: return bus.out_c;
            3: return bus.out_d;
            4: return bus.out_e;
            5: return bus.out_f;
            6: return bus.out_g;
            default: return bus.out_h;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic s, input logic [15:0] d, input logic fr);
        @(negedge clock);
        bus.in_valid = v;
        bus.in_sof = s;
        bus.in_data = d;
        bus.frame_ready = fr;
        #1 rdy_pre = bus.in_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.frame_ready = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int se_cnt, fv_cnt, stalls;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_data = '0;
        bus.frame_ready = 1'b1;
        tbl[0] = '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        for (int k = 1; k < 7; k++) tbl[k] = '{1'b1, 1'b0, 16'(k + 1), 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[7] = '{1'b1, 1'b0, 16'h0008, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[9] = '{1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

        repeat (2) @(posedge clock);
        #1;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset frame_valid", bus.frame_valid, 0);
        chk("reset sync_err", bus.sync_err, 0);
        chk("reset frame_cnt", bus.frame_cnt, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("reset slot%0d", i), outs(i), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 11; k++) begin
            cyc(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].fr);
            chk($sformatf("vec%0d in_ready", k), rdy_pre, tbl[k].rdy);
            chk($sformatf("vec%0d frame_valid", k), bus.frame_valid, tbl[k].fv);
            chk($sformatf("vec%0d sync_err", k), bus.sync_err, tbl[k].se);
            chk($sformatf("vec%0d frame_cnt", k), bus.frame_cnt, tbl[k].cnt);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("frame1 slot%0d", i), outs(i), 16'(i + 1));

        // consumer stalls a finished frame for five cycles
        for (int w = 0; w < 8; w++) cyc(1'b1, w == 0, 16'h2000 + 16'(w), 1'b0);
        chk("stall fv raised", bus.frame_valid, 1);
        chk("stall frame_cnt", bus.frame_cnt, 2);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 16'hFFFF, 1'b0);
            chk($sformatf("stall%0d in_ready", k), rdy_pre, 0);
            chk($sformatf("stall%0d frame_valid", k), bus.frame_valid, 1);
            chk($sformatf("stall%0d sync_err", k), bus.sync_err, 0);
            chk($sformatf("stall%0d out_a", k), bus.out_a, 16'h2000);
            chk($sformatf("stall%0d out_h", k), bus.out_h, 16'h2007);
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        chk("release in_ready", rdy_pre, 1);
        chk("release frame_valid", bus.frame_valid, 0);
        chk("release sync_err", bus.sync_err, 0);
        chk("release out_b", bus.out_b, 16'h2001);
        chk("release frame_cnt", bus.frame_cnt, 2);

        // premature restart after three words
        do_reset();
        se_cnt = 0;
        for (int w = 0; w < 3; w++) begin
            cyc(1'b1, w == 0, 16'h1111 + 16'(w), 1'b1);
            se_cnt += int'(bus.sync_err);
        end
        cyc(1'b1, 1'b1, 16'hAAAA, 1'b1);
        chk("restart sync_err pulse", bus.sync_err, 1);
        se_cnt += int'(bus.sync_err);
        for (int w = 1; w < 8; w++) begin
            cyc(1'b1, 1'b0, 16'hA000 + 16'(w), 1'b1);
            se_cnt += int'(bus.sync_err);
        end
        chk("restart sync_err count", se_cnt, 1);
        chk("restart frame_valid", bus.frame_valid, 1);
        chk("restart frame_cnt", bus.frame_cnt, 1);
        chk("restart out_a", bus.out_a, 16'hAAAA);
        chk("restart out_b", bus.out_b, 16'hA001);
        chk("restart out_h", bus.out_h, 16'hA007);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);

        // reset lands after slot 5 of a partial frame
        for (int w = 0; w < 6; w++) cyc(1'b1, w == 0, 16'h5000 + 16'(w), 1'b1);
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("midreset frame_valid", bus.frame_valid, 0);
        chk("midreset sync_err", bus.sync_err, 0);
        chk("midreset frame_cnt", bus.frame_cnt, 0);
        chk("midreset in_ready", bus.in_ready, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("midreset slot%0d", i), outs(i), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int w = 0; w < 8; w++) cyc(1'b1, w == 0, 16'h6000 + 16'(w), 1'b1);
        chk("fresh frame_valid", bus.frame_valid, 1);
        chk("fresh frame_cnt", bus.frame_cnt, 1);
        chk("fresh out_e", bus.out_e, 16'h6004);
        chk("fresh out_h", bus.out_h, 16'h6007);

        // 256 back-to-back frames wrap the frame counter
        do_reset();
        se_cnt = 0;
        fv_cnt = 0;
        stalls = 0;
        for (int f = 0; f < 256; f++) begin
            for (int w = 0; w < 8; w++) begin
                cyc(1'b1, w == 0, {8'(f), 8'(w)}, 1'b1);
                stalls += int'(!rdy_pre);
                se_cnt += int'(bus.sync_err);
                fv_cnt += int'(bus.frame_valid);
            end
            if (f == 254) chk("b2b frame_cnt 255", bus.frame_cnt, 255);
        end
        chk("b2b stalls", stalls, 0);
        chk("b2b sync_err", se_cnt, 0);
        chk("b2b frames", fv_cnt, 256);
        chk("b2b frame_cnt wrap", bus.frame_cnt, 0);
        chk("b2b out_a", bus.out_a, 16'hFF00);
        chk("b2b out_h", bus.out_h, 16'hFF07);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
